// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller around an external 1-bit full adder.
// Ports: clk, rst_n; in_valid/in_ready + in_a, in_b, in_cin operands;
//   fa_a, fa_b, fa_cin to adder, fa_s, fa_cout from adder;
//   out_valid/out_ready + out_sum, out_cout, out_ovf result.
// Macro SERIAL_ADD_OVF_EN: register signed overflow on out_ovf
//   (undefined: out_ovf tied 0).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             run;
  logic             last;
  logic             accept;

  assign run    = (state == RUN);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && in_valid;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign fa_a   = run & sh_a[0];
  assign fa_b   = run & sh_b[0];
  assign fa_cin = run & carry;

  // New sum bit enters at the MSB; after WIDTH shifts
  // bit 0 of the result sits in sum_sr[0].
  assign sum_nx = (sum_sr >> 1)
                | {fa_s, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (accept) begin
      sh_a  <= in_a;
      sh_b  <= in_b;
      carry <= in_cin;
      cnt   <= '0;
    end else if (run) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      sum_sr <= sum_nx;
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
      if (last) begin
        out_sum  <= sum_nx;
        out_cout <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // carry still holds the carry into the MSB on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_ovf <= 1'b0;
    else if (run && last)
      out_ovf <= carry ^ fa_cout;
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural
// full adder closing the fa_* loop.
module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         fa_a, fa_b, fa_cin;
  logic         fa_s, fa_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W+1:0] q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin)
                 | (fa_b & fa_cin);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_s(fa_s), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf)
  );

  // monitor: one pop per completed output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W+1:0] e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got sum=%h c=%b o=%b",
                 out_sum, out_cout, out_ovf);
      end else begin
        e = q.pop_front();
        if ({out_sum, out_cout, out_ovf} !== e) begin
          errors++;
          $display("FAIL result got sum=%h c=%b o=%b exp sum=%h c=%b o=%b",
                   out_sum, out_cout, out_ovf,
                   e[W+1:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input bit push,
                       input logic [W-1:0] es, input logic ec,
                       input logic eo, output int acc);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout got in_ready=0 exp 1");
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    if (push) q.push_back({es, ec, eo & OVF_ON});
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    in_cin = 1'(~cin);
    chk("first_fa_cin", 32'(fa_cin), 32'(cin));
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, 32'(n), 32'(W));
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         c, o;
  } vec_t;

  vec_t bb[6];
  int acc, prev;

  initial begin
    bb[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    bb[1] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    bb[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    bb[3] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
    bb[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    bb[5] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

    // reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_cout_ovf", {30'd0, out_cout, out_ovf}, 32'd0);
    chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // backpressure with ignored in_valid
    out_ready = 1'b0;
    issue(8'h5A, 8'h33, 1'b0, 1, 8'h8D, 1'b0, 1'b1, acc);
    wait_done("latency_5a33");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
      @(posedge clk); #1;
      chk("stall_hs", {30'd0, out_valid, in_ready}, 32'd2);
      chk("stall_res", {22'd0, out_sum, out_cout, out_ovf},
          {22'd0, 8'h8D, 1'b0, OVF_ON});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_idle", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_ghost", {30'd0, out_valid, in_ready}, 32'd1);

    // reset during bit 3 of RUN
    issue(8'hAA, 8'h0F, 1'b0, 0, 8'h00, 1'b0, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_hs", {30'd0, out_valid, in_ready}, 32'd1);
    chk("midrst_sum", 32'(out_sum), 32'd0);
    chk("midrst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0, 1'b0, acc);
    wait_done("latency_1234");

    // back-to-back, out_ready held high
    for (int i = 0; i < 6; i++) begin
      prev = acc;
      issue(bb[i].a, bb[i].b, bb[i].cin, 1,
            bb[i].s, bb[i].c, bb[i].o, acc);
      if (i > 0) chk("spacing", 32'(acc - prev), 32'(W + 2));
      wait_done("latency_bb");
    end

    begin
      int n = 0;
      while (q.size() != 0 && n < 20) begin
        @(posedge clk); n++;
      end
    end
    #1;
    chk("queue_drain", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
